// File: rtl/viterbi_frame_ctrl.sv
// Frame controller for an encoder/Viterbi-decoder pair: streams payload plus a zero tail into the
// encoder and re-aligns the decoded stream. Optional `VITERBI_FRAME_SELFCHECK_EN adds err_cnt_o.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN   = 64,
  parameter int TAIL_LEN    = 2,
  parameter int DEC_LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic abort_i,
  input  logic data_i,
  input  logic data_valid_i,
  output logic data_ready_o,
  output logic encoder_o,
  output logic enable_encoder_o,
  input  logic decoder_i,
  output logic dec_data_o,
  output logic dec_valid_o,
  output logic frame_done_o,
  output logic busy_o,
  output logic underrun_o
`ifdef VITERBI_FRAME_SELFCHECK_EN
  ,
  output logic [$clog2(FRAME_LEN+1)-1:0] err_cnt_o
`endif
);

  localparam int ENC_LEN = FRAME_LEN + TAIL_LEN;
  localparam int WIN_END = DEC_LATENCY + FRAME_LEN;
  localparam int CW      = $clog2(ENC_LEN + 1);
  localparam int WW      = $clog2(WIN_END + 1);

  localparam logic [CW-1:0] LAST_SLOT = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] LAST_ENC  = CW'(ENC_LEN - 1);
  localparam logic [CW-1:0] ENC_ONE   = CW'(1);
  localparam logic [WW-1:0] WIN_LO    = WW'(DEC_LATENCY);
  localparam logic [WW-1:0] WIN_HI    = WW'(WIN_END - 1);
  localparam logic [WW-1:0] WIN_ONE   = WW'(1);

  typedef enum logic [2:0] {IDLE, PAYLOAD, TAIL, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] enc_cnt;
  logic [WW-1:0] win_cnt;
  logic          win_run;
  logic          win_fin;

  logic kill;
  logic frame_start;
  logic win_start;
  logic capture;

  assign kill         = abort_i && (state != IDLE);
  assign frame_start  = (state == IDLE) && start_i && !abort_i;
  assign win_start    = (state == PAYLOAD) && (enc_cnt == '0) && !abort_i;
  assign capture      = win_run && (win_cnt >= WIN_LO);
  assign data_ready_o = (state == PAYLOAD);
  assign busy_o       = (state != IDLE);

  // Sequencer: payload slots, zero tail, then wait for the decoded window to close.
  // NOTE: every state register uses <= so all branches see pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      enc_cnt          <= '0;
      encoder_o        <= 1'b0;
      enable_encoder_o <= 1'b0;
      frame_done_o     <= 1'b0;
      underrun_o       <= 1'b0;
    end else begin
      encoder_o        <= 1'b0;
      enable_encoder_o <= 1'b0;
      frame_done_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state      <= PAYLOAD;
            enc_cnt    <= '0;
            underrun_o <= 1'b0;
          end
        end
        PAYLOAD: begin
          encoder_o        <= data_valid_i & data_i;
          enable_encoder_o <= 1'b1;
          if (!data_valid_i) underrun_o <= 1'b1;
          enc_cnt <= enc_cnt + ENC_ONE;
          if (enc_cnt == LAST_SLOT) state <= (TAIL_LEN == 0) ? DRAIN : TAIL;
        end
        TAIL: begin
          enable_encoder_o <= 1'b1;
          enc_cnt          <= enc_cnt + ENC_ONE;
          if (enc_cnt == LAST_ENC) state <= DRAIN;
        end
        DRAIN: begin
          if (win_fin) begin
            state        <= DONE;
            frame_done_o <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (kill) begin
        state            <= IDLE;
        encoder_o        <= 1'b0;
        enable_encoder_o <= 1'b0;
        frame_done_o     <= 1'b0;
      end
    end
  end

  // Output window is timed from the first encoder-enable cycle, independent of the sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_run     <= 1'b0;
      win_cnt     <= '0;
      win_fin     <= 1'b0;
      dec_valid_o <= 1'b0;
      dec_data_o  <= 1'b0;
    end else begin
      dec_data_o  <= decoder_i;
      dec_valid_o <= 1'b0;
      if (frame_start) win_fin <= 1'b0;
      if (win_start) begin
        win_run <= 1'b1;
        win_cnt <= '0;
      end else if (win_run) begin
        win_cnt <= win_cnt + WIN_ONE;
        if (capture) dec_valid_o <= 1'b1;
        if (win_cnt == WIN_HI) begin
          win_run <= 1'b0;
          win_fin <= 1'b1;
        end
      end
      if (kill) begin
        win_run     <= 1'b0;
        dec_valid_o <= 1'b0;
      end
    end
  end

`ifdef VITERBI_FRAME_SELFCHECK_EN
  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [$clog2(FRAME_LEN+1)-1:0] ERR_ONE = ($clog2(FRAME_LEN+1))'(1);

  logic [FRAME_LEN-1:0] hist;
  logic [IW-1:0]        wr_idx;
  logic [IW-1:0]        rd_idx;

  // NOTE: history is pure data storage with no reset; each slot is written before it is compared.
  always_ff @(posedge clk) begin
    if (state == PAYLOAD) hist[wr_idx] <= data_valid_i & data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      err_cnt_o <= '0;
    end else begin
      if (frame_start) begin
        wr_idx    <= '0;
        err_cnt_o <= '0;
      end else if (state == PAYLOAD) begin
        wr_idx <= wr_idx + IDX_ONE;
      end
      if (win_start) begin
        rd_idx <= '0;
      end else if (capture && !kill) begin
        rd_idx <= rd_idx + IDX_ONE;
        if (decoder_i != hist[rd_idx]) err_cnt_o <= err_cnt_o + ERR_ONE;
      end
    end
  end
`endif

endmodule

// File: doc/viterbi_frame_ctrl.md
VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 64: payload bits per frame; legal range 2..1024.
REQ-002 Parameter TAIL_LEN, default 2: zero flush bits appended per frame (K-1).
REQ-003 Parameter DEC_LATENCY, default 32: cycles from a bit on encoder_o to the matching bit on decoder_i; legal range ≥1.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 start_i  input  1  one-cycle pulse requesting a new frame.
REQ-007 abort_i  input  1  terminates the current frame.
REQ-008 data_i  input  1  payload bit.
REQ-009 data_valid_i  input  1  data_i is valid.
REQ-010 data_ready_o  output  1  controller accepts a payload bit this cycle.
REQ-011 encoder_o  output  1  bit to encoder input encoder_i.
REQ-012 enable_encoder_o  output  1  drives encoder enable_encoder_i.
REQ-013 decoder_i  input  1  decoder output decoder_o.
REQ-014 dec_data_o  output  1  aligned decoded payload bit.
REQ-015 dec_valid_o  output  1  dec_data_o is a payload bit.
REQ-016 frame_done_o  output  1  one-cycle end-of-frame pulse.
REQ-017 busy_o  output  1  high whenever the state is not IDLE.
REQ-018 underrun_o  output  1  sticky flag: a payload slot was filled with 0.

Function
REQ-019 The FSM SHALL have states IDLE, PAYLOAD, TAIL, DRAIN, DONE.
REQ-020 IDLE->PAYLOAD on start_i; start_i in any other state SHALL be ignored.
REQ-021 data_ready_o SHALL equal (state==PAYLOAD), combinationally.
REQ-022 Each PAYLOAD cycle SHALL consume one slot: encoder_o <= data_valid_i ? data_i : 0, enable_encoder_o <= 1 (registered); if data_valid_i is low, underrun_o SHALL set.
REQ-023 After FRAME_LEN slots, PAYLOAD->TAIL; TAIL SHALL drive encoder_o=0, enable_encoder_o=1 for TAIL_LEN cycles, then go to DRAIN.
REQ-024 enable_encoder_o SHALL be high for exactly FRAME_LEN+TAIL_LEN consecutive cycles per frame, low otherwise.
REQ-025 Call P0 the first cycle with enable_encoder_o high; dec_data_o SHALL be decoder_i registered, with dec_valid_o high for exactly FRAME_LEN cycles starting at P0+DEC_LATENCY+1.
REQ-026 The output-window counter SHALL run independently of FSM state, so window overlap with PAYLOAD/TAIL is legal.
REQ-027 DRAIN->DONE in the cycle after the last dec_valid_o; DONE SHALL pulse frame_done_o for one cycle, then go to IDLE.
REQ-028 abort_i in any non-IDLE state SHALL return to IDLE next cycle, clear enable_encoder_o and dec_valid_o, and SHALL NOT pulse frame_done_o.
REQ-029 If start_i and abort_i are both high in IDLE, abort_i SHALL win and no frame starts.
REQ-030 underrun_o SHALL clear when a new frame starts.
REQ-031 Counters SHALL be sized $clog2(max+1) and SHALL NOT wrap within a frame.

Reset
REQ-032 rst low SHALL force state IDLE, clear all counters, and drive every output (including underrun_o and err_cnt_o) to 0 immediately.
REQ-033 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait in IDLE for start_i.

Configuration
REQ-034 With macro VITERBI_FRAME_SELFCHECK_EN defined:
- the block SHALL store each frame's payload slots in a FRAME_LEN-bit history;
- it SHALL compare each dec_valid_o bit against that history;
- it SHALL expose output err_cnt_o, width $clog2(FRAME_LEN+1), holding the mismatch count;
- err_cnt_o SHALL clear on frame start and hold after frame_done_o.
REQ-035 Without the macro, the history register, the comparison logic and port err_cnt_o SHALL be absent.

Verification
REQ-036 Reset, then start_i with a 64-bit pattern (1001100011100001111000001111 repeated), data_valid_i always high -> enable_encoder_o high 66 cycles; dec_valid_o high 64 cycles from P0+33; dec_data_o equals the pattern; one frame_done_o pulse; err_cnt_o=0.
REQ-037 data_valid_i low on payload slots 10 and 11 -> underrun_o=1; encoder_o=0 in those slots; decoded bits 10 and 11 are 0.
REQ-038 abort_i at P0+20 -> IDLE next cycle; enable_encoder_o and dec_valid_o low; no frame_done_o; busy_o=0.
REQ-039 start_i pulses during PAYLOAD and DRAIN -> ignored; exactly one frame; the next start_i after frame_done_o starts a fresh frame.
REQ-040 rst low at P0+40, released 3 cycles later -> all outputs 0 during reset; IDLE afterwards; start_i with abort_i in the same cycle -> no frame.
REQ-041 VITERBI_FRAME_SELFCHECK_EN defined, decoder_i bit 5 forced inverted -> err_cnt_o=1 after frame_done_o.
